// File: rtl/mfcc_pkg.sv
// Shared types and helpers for the MFCC front-end frame buffer.
package mfcc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_OFFER,
    ST_WAIT_RD,
    ST_WAIT_DONE
  } frame_state_t;

  localparam int unsigned Q15_SHIFT = 15;

  // Clamp a signed value into the signed range of 'width' bits.
  function automatic logic signed [31:0] sat_to_width(input logic signed [32:0] v,
                                                      input int unsigned width);
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    hi = (33'sd1 <<< (width - 1)) - 33'sd1;
    lo = -(33'sd1 <<< (width - 1));
    if (v > hi) return hi[31:0];
    if (v < lo) return lo[31:0];
    return v[31:0];
  endfunction

endpackage

// File: rtl/mfcc_frame_buffer_if.sv
// Frame handshake between the frame buffer (master) and the Hamming window stage (slave).
interface mfcc_frame_buffer_if #(
  parameter int unsigned SAMPLE_WIDTH = 16
);
  logic                           start_o;
  logic                           valid_to_read_o;
  logic                           rd_en_i;
  logic signed [SAMPLE_WIDTH-1:0] frame_sample_o;
  logic                           window_done_i;

  modport master (
    output start_o, valid_to_read_o, frame_sample_o,
    input  rd_en_i, window_done_i
  );

  modport slave (
    input  start_o, valid_to_read_o, frame_sample_o,
    output rd_en_i, window_done_i
  );
endinterface

// File: rtl/mfcc_dp_ram.sv
// Simple dual-port RAM: one write port, one registered synchronous read port.
module mfcc_dp_ram #(
  parameter int unsigned DEPTH  = 512,
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/mfcc_frame_buffer.sv
// Pre-emphasis filter feeding a circular buffer that serves overlapping frames
// to the window stage over a single-cycle offer / rd_en handshake.
module mfcc_frame_buffer
  import mfcc_pkg::*;
#(
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned FRAME_SIZE   = 306,
  parameter int unsigned HOP_SIZE     = 153,
  parameter int unsigned BUFFER_DEPTH = 512,
  parameter int          ALPHA_Q15    = 31785
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic signed [SAMPLE_WIDTH-1:0] sample_i,
  input  logic                           sample_valid_i,
  mfcc_frame_buffer_if.master            win,
  output logic                           overflow_o,
  output logic [15:0]                    frame_count_o
);
  localparam int unsigned ADDR_W = $clog2(BUFFER_DEPTH);
  localparam int unsigned PTR_W  = ADDR_W + 1;
  localparam int unsigned SRV_W  = $clog2(FRAME_SIZE + 1);
  localparam int unsigned W1     = SAMPLE_WIDTH + 1;

  frame_state_t                   state;
  logic [PTR_W-1:0]               wr_ptr;
  logic [PTR_W-1:0]               frame_base;
  logic [PTR_W-1:0]               fill;
  logic [ADDR_W-1:0]              rd_ptr;
  logic [ADDR_W-1:0]              rd_addr;
  logic [SRV_W-1:0]               served;
  logic signed [SAMPLE_WIDTH-1:0] prev_x;
  logic signed [SAMPLE_WIDTH-1:0] y;
  logic signed [31:0]             prod;
  logic signed [W1-1:0]           diff;
  logic [SAMPLE_WIDTH-1:0]        ram_q;
  logic                           full;
  logic                           wr_en;
  logic                           consume;

  assign fill    = wr_ptr - frame_base;
  assign full    = (fill == PTR_W'(BUFFER_DEPTH));
  assign wr_en   = sample_valid_i && !full;
  assign consume = (state == ST_WAIT_RD) && win.rd_en_i;
  // Read ahead on the consuming cycle so the next offer lands two cycles after rd_en.
  assign rd_addr = consume ? rd_ptr + ADDR_W'(1) : rd_ptr;

  always_comb begin
    prod = ALPHA_Q15 * 32'(prev_x);
    diff = W1'(sample_i) - W1'(prod >>> Q15_SHIFT);
    y    = SAMPLE_WIDTH'(sat_to_width(33'(diff), SAMPLE_WIDTH));
  end

  mfcc_dp_ram #(
    .DEPTH (BUFFER_DEPTH),
    .WIDTH (SAMPLE_WIDTH),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .we   (wr_en),
    .waddr(wr_ptr[ADDR_W-1:0]),
    .wdata(y),
    .raddr(rd_addr),
    .rdata(ram_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= ST_IDLE;
      wr_ptr             <= '0;
      frame_base         <= '0;
      rd_ptr             <= '0;
      served             <= '0;
      prev_x             <= '0;
      overflow_o         <= 1'b0;
      frame_count_o      <= '0;
      win.start_o        <= 1'b0;
      win.valid_to_read_o <= 1'b0;
      win.frame_sample_o <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        prev_x <= sample_i;
      end
      if (sample_valid_i && full) overflow_o <= 1'b1;

      win.start_o         <= 1'b0;
      win.valid_to_read_o <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (fill >= PTR_W'(FRAME_SIZE)) begin
            rd_ptr      <= frame_base[ADDR_W-1:0];
            served      <= '0;
            win.start_o <= 1'b1;
            state       <= ST_START;
          end
        end
        ST_START: state <= ST_OFFER;
        ST_OFFER: begin
          win.frame_sample_o  <= $signed(ram_q);
          win.valid_to_read_o <= 1'b1;
          state               <= ST_WAIT_RD;
        end
        ST_WAIT_RD: begin
          if (win.rd_en_i) begin
            rd_ptr <= rd_ptr + ADDR_W'(1);
            served <= served + SRV_W'(1);
            state  <= (served == SRV_W'(FRAME_SIZE - 1)) ? ST_WAIT_DONE : ST_OFFER;
          end
        end
        ST_WAIT_DONE: begin
          if (win.window_done_i) begin
            frame_base    <= frame_base + PTR_W'(HOP_SIZE);
            frame_count_o <= frame_count_o + 16'd1;
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mfcc_frame_buffer.sv
// Self-checking bench for mfcc_frame_buffer against a sample-queue reference model.
module tb_mfcc_frame_buffer;
  localparam int SW    = 16;
  localparam int FS    = 306;
  localparam int HOP   = 153;
  localparam int DEPTH = 512;
  localparam int ALPHA = 31785;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic signed [SW-1:0] sample_i = '0;
  logic                 sample_valid_i = 1'b0;
  logic                 overflow_o;
  logic [15:0]          frame_count_o;

  mfcc_frame_buffer_if #(.SAMPLE_WIDTH(SW)) win ();

  mfcc_frame_buffer #(
    .SAMPLE_WIDTH(SW),
    .FRAME_SIZE  (FS),
    .HOP_SIZE    (HOP),
    .BUFFER_DEPTH(DEPTH),
    .ALPHA_Q15   (ALPHA)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sample_i      (sample_i),
    .sample_valid_i(sample_valid_i),
    .win           (win),
    .overflow_o    (overflow_o),
    .frame_count_o (frame_count_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ys[$];
  int got[$];
  int stim[$];
  int prev_x = 0;
  int base = 0;
  int exp_frames = 0;
  bit exp_ovf = 1'b0;

  // y = x - floor(alpha*prev/2^15), clamped to 16-bit signed
  function automatic int preemph(input int x, input int p);
    longint prod;
    longint q;
    longint yv;
    prod = longint'(ALPHA) * longint'(p);
    q = prod / 32768;
    if (prod < 0 && (prod % 32768) != 0) q = q - 1;
    yv = longint'(x) - q;
    if (yv > 32767) yv = 32767;
    if (yv < -32768) yv = -32768;
    return int'(yv);
  endfunction

  task automatic model_reset();
    ys.delete();
    prev_x = 0;
    base = 0;
    exp_frames = 0;
    exp_ovf = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    sample_valid_i = 1'b0;
    win.rd_en_i = 1'b0;
    win.window_done_i = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic push_sample(input int x);
    sample_i = SW'(x);
    sample_valid_i = 1'b1;
    if (ys.size() - base == DEPTH) exp_ovf = 1'b1;
    else begin
      ys.push_back(preemph(x, prev_x));
      prev_x = x;
    end
    @(negedge clk);
    sample_valid_i = 1'b0;
  endtask

  task automatic feed_stim(input int gmin, input int gmax);
    foreach (stim[k]) begin
      push_sample(stim[k]);
      repeat ($urandom_range(gmax, gmin)) @(negedge clk);
    end
  endtask

  function automatic int rnd_sample();
    return int'($urandom_range(65535, 0)) - 32768;
  endfunction

  task automatic pulse_done();
    win.window_done_i = 1'b1;
    @(negedge clk);
    win.window_done_i = 1'b0;
    base = base + HOP;
    exp_frames++;
    checks++;
    if (frame_count_o !== 16'(exp_frames)) begin
      errors++;
      $display("FAIL frame_count: got %0d want %0d", frame_count_o, exp_frames);
    end
  endtask

  // Window-stage model: registered rd_en one cycle after each offer.
  task automatic serve_frame(input int nserve, input bit give_done, input int hold,
                             input bit cadence, input bit stray);
    int waitc;
    int exp;
    waitc = 0;
    while (win.start_o !== 1'b1 && waitc < 8000) begin
      @(negedge clk);
      waitc++;
    end
    checks++;
    if (win.start_o !== 1'b1) begin
      errors++;
      $display("FAIL start_seen frame %0d: got %b want 1", exp_frames, win.start_o);
      return;
    end
    got.delete();
    waitc = 0;
    for (int i = 0; i < nserve; i++) begin
      while (win.valid_to_read_o !== 1'b1 && waitc < 64) begin
        @(negedge clk);
        waitc++;
        if (waitc >= hold) win.rd_en_i = 1'b0;
      end
      checks++;
      if (win.valid_to_read_o !== 1'b1) begin
        errors++;
        $display("FAIL valid_seen frame %0d sample %0d: got %b want 1", exp_frames, i,
                 win.valid_to_read_o);
        win.rd_en_i = 1'b0;
        return;
      end
      if (cadence) begin
        checks++;
        if (waitc != 2) begin
          errors++;
          $display("FAIL cadence sample %0d: got %0d cycles want 2", i, waitc);
        end
      end
      exp = (base + i < ys.size()) ? ys[base + i] : 100000;
      checks++;
      if (int'(win.frame_sample_o) !== exp) begin
        errors++;
        $display("FAIL frame_sample frame %0d idx %0d: got %0d want %0d", exp_frames, i,
                 int'(win.frame_sample_o), exp);
      end
      got.push_back(int'(win.frame_sample_o));
      if (stray && i == 5) win.window_done_i = 1'b1;
      @(negedge clk);
      win.rd_en_i = 1'b1;
      win.window_done_i = 1'b0;
      waitc = 0;
    end
    @(negedge clk);
    win.rd_en_i = 1'b0;
    if (give_done) pulse_done();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    win.rd_en_i = 1'b0;
    win.window_done_i = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({win.start_o, win.valid_to_read_o, overflow_o} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 000", {win.start_o, win.valid_to_read_o, overflow_o});
    end
    checks++;
    if (win.frame_sample_o !== 16'sd0) begin
      errors++;
      $display("FAIL reset_sample: got %0d want 0", win.frame_sample_o);
    end
    checks++;
    if (frame_count_o !== 16'd0) begin
      errors++;
      $display("FAIL reset_count: got %0d want 0", frame_count_o);
    end
    model_reset();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_preemph_const();
    for (int i = 0; i < FS; i++) push_sample(1000);
    serve_frame(FS, 1'b1, 2, 1'b1, 1'b1);
    checks++;
    if (got.size() != FS || got[0] !== 1000 || got[FS-1] !== 30) begin
      errors++;
      $display("FAIL const_ends: got n=%0d first=%0d last=%0d want n=%0d 1000 30",
               got.size(), got.size() > 0 ? got[0] : 0, got.size() > 0 ? got[got.size()-1] : 0, FS);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (win.start_o !== 1'b0 || frame_count_o !== 16'd1) begin
      errors++;
      $display("FAIL const_single_frame: start=%b count=%0d want 0 1", win.start_o, frame_count_o);
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    push_sample(32767);
    push_sample(-32768);
    for (int i = 2; i < FS; i++) push_sample(rnd_sample());
    serve_frame(FS, 1'b1, 1, 1'b0, 1'b0);
    checks++;
    if (got.size() < 2 || got[1] !== -32768) begin
      errors++;
      $display("FAIL saturation: got %0d want -32768", got.size() > 1 ? got[1] : 0);
    end
  endtask

  task automatic test_ramp();
    apply_reset();
    stim.delete();
    for (int n = 0; n < 2 * FS; n++) stim.push_back(n);
    fork
      feed_stim(6, 10);
      begin
        for (int f = 0; f < 3; f++) serve_frame(FS, 1'b1, 1, 1'b0, 1'b0);
      end
    join
    checks++;
    if (overflow_o !== exp_ovf || frame_count_o !== 16'd3) begin
      errors++;
      $display("FAIL ramp_end: ovf=%b count=%0d want %b 3", overflow_o, frame_count_o, exp_ovf);
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    stim.delete();
    for (int n = 0; n < 600; n++) stim.push_back(rnd_sample());
    fork
      feed_stim(0, 0);
      serve_frame(FS, 1'b0, 1, 1'b0, 1'b0);
    join
    checks++;
    if (overflow_o !== 1'b1 || exp_ovf !== 1'b1) begin
      errors++;
      $display("FAIL overflow_set: got %b want 1", overflow_o);
    end
    pulse_done();
    serve_frame(FS, 1'b1, 1, 1'b0, 1'b0);
    checks++;
    if (overflow_o !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sticky: got %b want 1", overflow_o);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    stim.delete();
    for (int n = 0; n < 9 * HOP + FS; n++) stim.push_back(rnd_sample());
    fork
      feed_stim(6, 10);
      begin
        for (int f = 0; f < 10; f++) serve_frame(FS, 1'b1, 1, 1'b0, 1'b0);
      end
    join
    checks++;
    if (overflow_o !== exp_ovf || frame_count_o !== 16'd10) begin
      errors++;
      $display("FAIL wrap_end: ovf=%b count=%0d want %b 10", overflow_o, frame_count_o, exp_ovf);
    end
  endtask

  task automatic test_reset_midframe();
    int starts;
    while (ys.size() - base < FS) push_sample(rnd_sample());
    serve_frame(100, 1'b0, 1, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({win.start_o, win.valid_to_read_o, overflow_o} !== 3'b000 ||
        win.frame_sample_o !== 16'sd0 || frame_count_o !== 16'd0) begin
      errors++;
      $display("FAIL midframe_reset: start=%b valid=%b ovf=%b sample=%0d count=%0d want all 0",
               win.start_o, win.valid_to_read_o, overflow_o, win.frame_sample_o, frame_count_o);
    end
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < FS - 1; i++) push_sample(rnd_sample());
    starts = 0;
    repeat (10) begin
      if (win.start_o === 1'b1) starts++;
      @(negedge clk);
    end
    checks++;
    if (starts != 0) begin
      errors++;
      $display("FAIL early_start: got %0d starts want 0", starts);
    end
    push_sample(rnd_sample());
    serve_frame(FS, 1'b1, 1, 1'b0, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    win.rd_en_i = 1'b0;
    win.window_done_i = 1'b0;
    test_reset();
    test_preemph_const();
    test_saturation();
    test_ramp();
    test_overflow();
    test_wrap();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mfcc_frame_buffer.md
Name: mfcc_frame_buffer

Overview:
Upstream neighbour of the Hamming window stage. Accepts the raw PCM sample stream and applies first-order pre-emphasis, y[n] = x[n] - ALPHA*x[n-1]. Stores results in a circular buffer, then serves overlapping frames of FRAME_SIZE samples, advancing HOP_SIZE per frame. Drives the window stage's start / valid_to_read / rd_en / frame_sample handshake and waits for its done pulse before launching the next frame.

Parameters:
SAMPLE_WIDTH, 16, signed PCM and output sample width
FRAME_SIZE, 306, samples per frame (equals window coefficient count)
HOP_SIZE, 153, frame advance in samples; 1 <= HOP_SIZE <= FRAME_SIZE
BUFFER_DEPTH, 512, circular buffer entries; power of two, > FRAME_SIZE
ALPHA_Q15, 31785, pre-emphasis coefficient in Q1.15 (0.97)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
sample_i  in  SAMPLE_WIDTH  signed PCM input sample
sample_valid_i  in  1  one-cycle strobe: sample_i valid
start_o  out  1  one-cycle pulse: frame ready, window stage may begin
valid_to_read_o  out  1  frame_sample_o holds the next unread sample of the current frame
rd_en_i  in  1  window stage has consumed the offered sample
frame_sample_o  out  SAMPLE_WIDTH  signed pre-emphasised sample
window_done_i  in  1  one-cycle pulse from the window stage: frame fully processed
overflow_o  out  1  sticky: an input sample was dropped; cleared only by reset
frame_count_o  out  16  frames issued, wraps modulo 2^16

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst_n. All state is cleared asynchronously.
- Reset values: start_o=0, valid_to_read_o=0, frame_sample_o=0, overflow_o=0, frame_count_o=0; wr_ptr=rd_ptr=frame_base=0; prev_x=0; FSM=IDLE.
- Pre-emphasis, on each sample_valid_i:
  - Compute prod = ALPHA_Q15 * prev_x as a 32-bit signed value.
  - Compute y = sample_i - (prod >>> 15) at SAMPLE_WIDTH+1 bits, then saturate to SAMPLE_WIDTH bits (max 32767, min -32768).
  - Update prev_x <= sample_i.
  - The first sample after reset uses prev_x=0.
- Write path: y is written at wr_ptr, then wr_ptr increments modulo BUFFER_DEPTH. fill = wr_ptr - frame_base (modulo, with an extra wrap bit).
- Overflow: if fill == BUFFER_DEPTH when sample_valid_i arrives, drop the sample, do not update prev_x, and set overflow_o.
- FSM states: IDLE, START, OFFER, WAIT_RD, WAIT_DONE.
  - IDLE -> START when fill >= FRAME_SIZE. Set rd_ptr=frame_base and served=0.
  - START: pulse start_o for one cycle -> OFFER.
  - OFFER: issue RAM read at rd_ptr (1-cycle latency). On the second cycle, register frame_sample_o and assert valid_to_read_o for exactly one cycle -> WAIT_RD.
  - WAIT_RD: valid_to_read_o=0. Wait for rd_en_i. Then rd_ptr++ and served++. If served == FRAME_SIZE -> WAIT_DONE, else -> OFFER.
  - WAIT_DONE: on window_done_i, frame_base += HOP_SIZE and frame_count_o++ -> IDLE.
- Cadence: the first sample is offered 2 cycles after start_o. After each rd_en_i, the next sample is offered 2 cycles later. Since valid is a single-cycle offer, the window stage's registered rd_en never double-consumes a sample.
- rd_en_i while not in WAIT_RD is ignored. window_done_i outside WAIT_DONE is ignored.
- Writes continue in every state. A simultaneous write and read is legal because the RAM is dual-port. The write never targets a slot in [frame_base, frame_base+FRAME_SIZE) while that frame is served, guaranteed by the overflow rule.
- Pointer wrap: all addresses are modulo BUFFER_DEPTH. A frame spanning the wrap reads contiguously in sample order.
- Reset mid-frame: the current frame is discarded and buffer contents are ignored; after reset release, start_o requires FRAME_SIZE new samples.

Decomposition:
- mfcc_pkg holds the FSM state typedef (frame_state_t), the Q15 fractional shift constant, and the saturation function.
- One sub-module, mfcc_dp_ram: a simple dual-port RAM, BUFFER_DEPTH x SAMPLE_WIDTH, with registered synchronous read and a write port.

Test Plan:
- Reset, then 306 samples all equal to 1000 -> one start_o; frame_sample_o sequence is 1000, then 30 repeated (1000 - 970). Model rd_en one cycle after each valid_to_read_o, pulse done -> frame_count_o=1.
- Continuous ramp x[n]=n, 612 samples, 3 frames -> frame k begins at input index 153k; every offered value matches the golden pre-emphasis model; no overflow.
- Saturation: x0=32767, x1=-32768 -> second output = -32768 (saturated, not wrapped).
- Withhold window_done_i while streaming 600 samples -> fill reaches 512, sample 513 dropped, overflow_o=1 and stays 1. Frame content is unchanged after done is released.
- Wrap: run 10 frames so that frame_base crosses 512 -> frame samples remain contiguous and match the model across the wrap.
- Assert rst_n low mid-frame (served=100) -> all outputs return to reset values immediately; the next start_o arrives only after 306 fresh samples.
